// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by an on-chip 128-bit word memory.
// Independent write (AW/W/B) and read (AR/R) paths, one outstanding burst each.
module axi_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         slaveAxi_aw_valid,
  output logic         slaveAxi_aw_ready,
  input  logic [31:0]  slaveAxi_aw_payload_addr,
  input  logic [7:0]   slaveAxi_aw_payload_len,
  input  logic [2:0]   slaveAxi_aw_payload_size,
  input  logic [1:0]   slaveAxi_aw_payload_burst,
  input  logic         slaveAxi_w_valid,
  output logic         slaveAxi_w_ready,
  input  logic [127:0] slaveAxi_w_payload_data,
  input  logic [15:0]  slaveAxi_w_payload_strb,
  input  logic         slaveAxi_w_payload_last,
  output logic         slaveAxi_b_valid,
  input  logic         slaveAxi_b_ready,
  output logic [1:0]   slaveAxi_b_payload_resp,
  input  logic         slaveAxi_ar_valid,
  output logic         slaveAxi_ar_ready,
  input  logic [31:0]  slaveAxi_ar_payload_addr,
  input  logic [7:0]   slaveAxi_ar_payload_len,
  input  logic [2:0]   slaveAxi_ar_payload_size,
  input  logic [1:0]   slaveAxi_ar_payload_burst,
  output logic         slaveAxi_r_valid,
  input  logic         slaveAxi_r_ready,
  output logic [127:0] slaveAxi_r_payload_data,
  output logic [1:0]   slaveAxi_r_payload_resp,
  output logic         slaveAxi_r_payload_last
);
  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 4;

  logic [127:0] mem [DEPTH_WORDS];

  // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail the span test.
  function automatic logic in_range(input logic [31:0] a);
    return {1'b0, a - BASE_ADDR} < SPAN;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 4);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? a + (32'd1 << size) : a;
  endfunction

  function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (size > 3'd4);
  endfunction

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_bad, w_dec, w_slv;
  logic        w_fire, w_beat_ok, w_final, mem_we, dec_n, slv_n;
  logic [1:0]  resp_n;

  always_comb begin
    w_fire    = slaveAxi_w_valid && slaveAxi_w_ready;
    w_beat_ok = in_range(w_addr);
    w_final   = (w_cnt == w_len);
    mem_we    = w_fire && w_beat_ok && !w_bad;
    // Flags for the final beat include that beat's own outcome.
    dec_n     = w_dec || (!w_bad && !w_beat_ok);
    slv_n     = w_slv || (slaveAxi_w_payload_last != w_final);
    resp_n    = dec_n ? 2'b11 : (slv_n ? 2'b10 : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (slaveAxi_w_payload_strb[i])
          mem[word_idx(w_addr)][i*8 +: 8] <= slaveAxi_w_payload_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state                 <= W_IDLE;
      slaveAxi_aw_ready       <= 1'b0;
      slaveAxi_w_ready        <= 1'b0;
      slaveAxi_b_valid        <= 1'b0;
      slaveAxi_b_payload_resp <= '0;
      w_addr                  <= '0;
      w_len                   <= '0;
      w_cnt                   <= '0;
      w_size                  <= '0;
      w_burst                 <= '0;
      w_bad                   <= 1'b0;
      w_dec                   <= 1'b0;
      w_slv                   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (slaveAxi_aw_ready && slaveAxi_aw_valid) begin
            w_addr            <= slaveAxi_aw_payload_addr;
            w_len             <= slaveAxi_aw_payload_len;
            w_size            <= slaveAxi_aw_payload_size;
            w_burst           <= slaveAxi_aw_payload_burst;
            w_cnt             <= '0;
            w_bad             <= unsupported(slaveAxi_aw_payload_size, slaveAxi_aw_payload_burst);
            w_slv             <= unsupported(slaveAxi_aw_payload_size, slaveAxi_aw_payload_burst);
            w_dec             <= 1'b0;
            slaveAxi_aw_ready <= 1'b0;
            slaveAxi_w_ready  <= 1'b1;
            w_state           <= W_DATA;
          end else begin
            slaveAxi_aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_dec  <= dec_n;
            w_slv  <= slv_n;
            if (w_final) begin
              slaveAxi_w_ready        <= 1'b0;
              slaveAxi_b_valid        <= 1'b1;
              slaveAxi_b_payload_resp <= resp_n;
              w_state                 <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (slaveAxi_b_ready) begin
            slaveAxi_b_valid        <= 1'b0;
            slaveAxi_b_payload_resp <= '0;
            w_state                 <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t     r_state;
  logic [31:0]  r_addr, ld_addr;
  logic [7:0]   r_len, r_cnt;
  logic [2:0]   r_size;
  logic [1:0]   r_burst, ld_resp;
  logic         r_bad, ld_bad, ld_last, ld_ok;
  logic [127:0] ld_data;

  // Next beat is fetched combinationally so streaming has no bubble; the array
  // read sees pre-edge contents, giving read-before-write on collisions.
  always_comb begin
    if (r_state == R_IDLE) begin
      ld_addr = slaveAxi_ar_payload_addr;
      ld_bad  = unsupported(slaveAxi_ar_payload_size, slaveAxi_ar_payload_burst);
      ld_last = (slaveAxi_ar_payload_len == 8'd0);
    end else begin
      ld_addr = next_addr(r_addr, r_size, r_burst);
      ld_bad  = r_bad;
      ld_last = ((r_cnt + 8'd1) == r_len);
    end
    ld_ok   = in_range(ld_addr);
    ld_data = (ld_ok && !ld_bad) ? mem[word_idx(ld_addr)] : '0;
    ld_resp = ld_bad ? 2'b10 : (ld_ok ? 2'b00 : 2'b11);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state                 <= R_IDLE;
      slaveAxi_ar_ready       <= 1'b0;
      slaveAxi_r_valid        <= 1'b0;
      slaveAxi_r_payload_data <= '0;
      slaveAxi_r_payload_resp <= '0;
      slaveAxi_r_payload_last <= 1'b0;
      r_addr                  <= '0;
      r_len                   <= '0;
      r_cnt                   <= '0;
      r_size                  <= '0;
      r_burst                 <= '0;
      r_bad                   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (slaveAxi_ar_ready && slaveAxi_ar_valid) begin
            r_addr                  <= slaveAxi_ar_payload_addr;
            r_len                   <= slaveAxi_ar_payload_len;
            r_size                  <= slaveAxi_ar_payload_size;
            r_burst                 <= slaveAxi_ar_payload_burst;
            r_cnt                   <= '0;
            r_bad                   <= ld_bad;
            slaveAxi_ar_ready       <= 1'b0;
            slaveAxi_r_valid        <= 1'b1;
            slaveAxi_r_payload_data <= ld_data;
            slaveAxi_r_payload_resp <= ld_resp;
            slaveAxi_r_payload_last <= ld_last;
            r_state                 <= R_DATA;
          end else begin
            slaveAxi_ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (slaveAxi_r_ready) begin
            if (slaveAxi_r_payload_last) begin
              slaveAxi_r_valid        <= 1'b0;
              slaveAxi_r_payload_data <= '0;
              slaveAxi_r_payload_resp <= '0;
              slaveAxi_r_payload_last <= 1'b0;
              r_state                 <= R_IDLE;
            end else begin
              r_addr                  <= ld_addr;
              r_cnt                   <= r_cnt + 8'd1;
              slaveAxi_r_payload_data <= ld_data;
              slaveAxi_r_payload_resp <= ld_resp;
              slaveAxi_r_payload_last <= ld_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed + random bursts against a
// byte-level reference memory kept in the bench.
module tb_axi_slave_mem;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam longint      SPAN  = longint'(DEPTH) * 16;

  logic         clk, resetn;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [31:0]  aw_addr, ar_addr;
  logic [7:0]   aw_len, ar_len;
  logic [2:0]   aw_size, ar_size;
  logic [1:0]   aw_burst, ar_burst, b_resp, r_resp;
  logic [127:0] w_data, r_data;
  logic [15:0]  w_strb;
  logic         ar_valid, ar_ready, r_valid, r_ready, r_last;

  axi_slave_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .slaveAxi_aw_valid(aw_valid), .slaveAxi_aw_ready(aw_ready),
    .slaveAxi_aw_payload_addr(aw_addr), .slaveAxi_aw_payload_len(aw_len),
    .slaveAxi_aw_payload_size(aw_size), .slaveAxi_aw_payload_burst(aw_burst),
    .slaveAxi_w_valid(w_valid), .slaveAxi_w_ready(w_ready),
    .slaveAxi_w_payload_data(w_data), .slaveAxi_w_payload_strb(w_strb),
    .slaveAxi_w_payload_last(w_last),
    .slaveAxi_b_valid(b_valid), .slaveAxi_b_ready(b_ready), .slaveAxi_b_payload_resp(b_resp),
    .slaveAxi_ar_valid(ar_valid), .slaveAxi_ar_ready(ar_ready),
    .slaveAxi_ar_payload_addr(ar_addr), .slaveAxi_ar_payload_len(ar_len),
    .slaveAxi_ar_payload_size(ar_size), .slaveAxi_ar_payload_burst(ar_burst),
    .slaveAxi_r_valid(r_valid), .slaveAxi_r_ready(r_ready),
    .slaveAxi_r_payload_data(r_data), .slaveAxi_r_payload_resp(r_resp),
    .slaveAxi_r_payload_last(r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [127:0] model [DEPTH];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] all_outs();
    return 192'({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, r_last});
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] sz, input logic [1:0] bu);
    return (bu == 2'b00) ? a : a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic bit inr(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + SPAN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 4);
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      wd[k] = {$urandom, $urandom, $urandom, $urandom};
      ws[k] = 16'hFFFF;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] sz,
                           input logic [1:0] bu, input bit early_last, input bit gaps,
                           output logic [1:0] resp);
    int t;
    bit unsup, dec, slv;
    logic [31:0] a;
    logic [1:0] exp_resp;
    unsup = bu[1] || (sz > 3'd4);
    dec = 0;
    slv = unsup;
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = addr; aw_len = 8'(len); aw_size = sz; aw_burst = bu;
    t = 0;
    while (!aw_ready && t < 50) begin @(negedge clk); t++; end
    check("aw_accept", 192'(aw_ready), 192'(1));
    @(negedge clk);
    aw_valid = 1'b0;
    check("w_ready_after_aw", 192'(w_ready), 192'(1));
    for (int i = 0; i <= len; i++) begin
      w_valid = 1'b0;
      while (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i];
      w_last = early_last ? (i == 0) : (i == len);
      t = 0;
      while (!w_ready && t < 50) begin @(negedge clk); t++; end
      check("w_ready", 192'(w_ready), 192'(1));
      a = beat_addr(addr, i, sz, bu);
      if (!unsup) begin
        if (inr(a)) begin
          for (int b = 0; b < 16; b++)
            if (ws[i][b]) model[widx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
        end else begin
          dec = 1;
        end
      end
      if (w_last != (i == len)) slv = 1;
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    b_ready = 1'b1;
    t = 0;
    while (!b_valid && t < 50) begin @(negedge clk); t++; end
    check("b_valid", 192'(b_valid), 192'(1));
    resp = b_resp;
    check("b_resp", 192'(b_resp), 192'(exp_resp));
    @(negedge clk);
    b_ready = 1'b0;
    check("b_valid_drop", 192'(b_valid), 192'(0));
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1 repeating, 2 random
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input int rmode, output logic [127:0] last_data);
    int t, i, cyc;
    bit unsup, prev_stall, prev_acc;
    logic [131:0] held;
    logic [127:0] ed;
    logic [1:0] er;
    logic [31:0] a;
    unsup = bu[1] || (sz > 3'd4);
    last_data = '0;
    held = '0;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr; ar_len = 8'(len); ar_size = sz; ar_burst = bu;
    t = 0;
    while (!ar_ready && t < 50) begin @(negedge clk); t++; end
    check("ar_accept", 192'(ar_ready), 192'(1));
    @(negedge clk);
    ar_valid = 1'b0;
    check("r_valid_first", 192'(r_valid), 192'(1));
    i = 0; cyc = 0; prev_stall = 0; prev_acc = 0;
    while (i <= len && cyc < 3000) begin
      r_ready = (rmode == 0) ? 1'b1 :
                (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      if (prev_stall) check("r_stable", 192'({r_data, r_resp, r_last, r_valid}), 192'(held));
      if (prev_acc) check("r_no_bubble", 192'(r_valid), 192'(1));
      prev_stall = r_valid && !r_ready;
      prev_acc = 0;
      held = {r_data, r_resp, r_last, r_valid};
      if (r_valid && r_ready) begin
        a = beat_addr(addr, i, sz, bu);
        if (unsup)         begin ed = '0;            er = 2'b10; end
        else if (!inr(a))  begin ed = '0;            er = 2'b11; end
        else               begin ed = model[widx(a)]; er = 2'b00; end
        check("r_data", 192'(r_data), 192'(ed));
        check("r_resp", 192'(r_resp), 192'(er));
        check("r_last", 192'(r_last), 192'(i == len));
        last_data = r_data;
        i++;
        prev_acc = (i <= len);
      end
      @(negedge clk);
      cyc++;
    end
    r_ready = 1'b0;
    check("r_beats", 192'(i), 192'(len + 1));
    check("r_idle", 192'(r_valid), 192'(0));
  endtask

  initial begin
    logic [1:0]   resp, resp2;
    logic [127:0] ld, ld2, keep;
    logic [31:0]  ra;
    int           rl;
    logic [2:0]   rs;
    logic [1:0]   rb;

    resetn = 1'b0;
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; r_ready = 0;
    for (int k = 0; k < int'(DEPTH); k++) model[k] = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    resetn = 1'b1;
    check("aw_ready_before_edge", 192'(aw_ready), 192'(0));
    @(negedge clk);
    check("aw_ready_up", 192'(aw_ready), 192'(1));
    check("ar_ready_up", 192'(ar_ready), 192'(1));

    // Whole-memory prefill so every later read has a defined expectation.
    fill_random(DEPTH);
    axi_write(32'h0, DEPTH - 1, 3'd4, 2'b01, 0, 1, resp);

    wd[0] = 128'h0123456789ABCDEF0123456789ABCDEF; ws[0] = 16'hFFFF;
    axi_write(32'h10, 0, 3'd4, 2'b01, 0, 0, resp);
    check("single_b_okay", 192'(resp), 192'(2'b00));
    axi_read(32'h10, 0, 3'd4, 2'b01, 0, ld);
    check("single_read_data", 192'(ld), 192'(128'h0123456789ABCDEF0123456789ABCDEF));

    for (int k = 0; k < 4; k++) begin wd[k] = {4{32'hA500_0000 + 32'(k)}}; ws[k] = 16'hFFFF; end
    axi_write(32'h100, 3, 3'd4, 2'b01, 0, 1, resp);
    check("incr_b_okay", 192'(resp), 192'(2'b00));
    axi_read(32'h100, 3, 3'd4, 2'b01, 1, ld);
    check("incr_last_word", 192'(ld), 192'({4{32'hA500_0003}}));

    wd[0] = '1; ws[0] = 16'hFFFF;
    axi_write(32'h200, 0, 3'd4, 2'b01, 0, 0, resp);
    wd[0] = '0; ws[0] = 16'h000F;
    axi_write(32'h200, 0, 3'd4, 2'b01, 0, 0, resp);
    axi_read(32'h200, 0, 3'd4, 2'b01, 0, ld);
    check("partial_strobe", 192'(ld), 192'({{96{1'b1}}, 32'h0}));

    fill_random(4);
    axi_write(BASE + DEPTH * 16, 0, 3'd4, 2'b01, 0, 0, resp);
    check("aw_out_of_range", 192'(resp), 192'(2'b11));
    axi_read(32'h100, 2, 3'd4, 2'b10, 0, ld);
    check("ar_burst10_data", 192'(ld), 192'(0));
    axi_write(32'h300, 1, 3'd4, 2'b01, 1, 0, resp);
    check("early_last_slverr", 192'(resp), 192'(2'b10));
    axi_write(32'h3E0, 3, 3'd4, 2'b01, 0, 0, resp);
    check("crossing_decerr", 192'(resp), 192'(2'b11));
    axi_read(32'h3E0, 3, 3'd4, 2'b01, 2, ld);
    axi_write(32'h80, 0, 3'd5, 2'b01, 0, 0, resp);
    check("size5_slverr", 192'(resp), 192'(2'b10));

    // Reset while beat 2 of an 8-beat read is on the bus.
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd4; ar_burst = 2'b01;
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_burst_valid", 192'(r_valid), 192'(1));
    resetn = 1'b0;
    #1;
    check("mid_burst_reset_outputs", all_outs(), '0);
    @(negedge clk);
    r_ready = 1'b0;
    resetn = 1'b1;
    check("ar_ready_held_low", 192'(ar_ready), 192'(0));
    @(negedge clk);
    check("ar_ready_after_release", 192'(ar_ready), 192'(1));
    axi_read(32'h0, 7, 3'd4, 2'b01, 0, ld);

    fill_random(4);
    keep = wd[3];
    fork
      axi_write(32'h40, 3, 3'd4, 2'b00, 0, 1, resp);
      axi_read(32'h100, 3, 3'd4, 2'b01, 2, ld2);
    join
    check("fixed_b_okay", 192'(resp), 192'(2'b00));
    check("concurrent_read", 192'(ld2), 192'({4{32'hA500_0003}}));
    axi_read(32'h40, 0, 3'd4, 2'b01, 0, ld);
    check("fixed_last_beat", 192'(ld), 192'(keep));

    fill_random(256);
    keep = wd[255];
    axi_write(32'h80, 255, 3'd4, 2'b00, 0, 0, resp);
    check("len255_b_okay", 192'(resp), 192'(2'b00));
    axi_read(32'h80, 255, 3'd4, 2'b00, 0, ld);
    check("len255_fixed_read", 192'(ld), 192'(keep));
    axi_read(32'h0, 255, 3'd2, 2'b01, 2, ld);

    for (int n = 0; n < 30; n++) begin
      ra = 32'($urandom_range(0, 32'h43F));
      rl = int'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
      rb = 2'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        wd[k] = {$urandom, $urandom, $urandom, $urandom};
        ws[k] = 16'($urandom);
      end
      if (n % 3 == 0) begin
        fork
          axi_write(ra & 32'h1FF, rl, rs, rb, 0, 1, resp2);
          axi_read((ra & 32'h1FF) | 32'h200, rl, rs, rb, 2, ld2);
        join
      end else begin
        axi_write(ra, rl, rs, rb, 0, 1, resp2);
        axi_read(ra, rl, rs, rb, 2, ld2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
